// File: rtl/byte_stream_packer.sv
// byte_stream_packer: packs a serialized 8-bit byte stream into 32-bit words, lane 0 holding the first byte.
// Latency: the word's completing byte at cycle N gives o_word_valid at N+1; output FIFO of DEPTH words.
// Backpressure: i_word_ready stalls the FIFO; a push into a full FIFO drops the word and sets sticky o_overflow.
// Optional: define PACKER_CHECKSUM_EN to build the 16-bit running byte sum; otherwise o_checksum is tied to zero.
module byte_stream_packer #(
  parameter int DEPTH = 4
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        i_start,
  input  logic [15:0] i_byte_len,
  input  logic [7:0]  i_byte,
  input  logic        i_byte_valid,
  output logic [31:0] o_word,
  output logic [3:0]  o_byte_en,
  output logic        o_last,
  output logic        o_word_valid,
  input  logic        i_word_ready,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_overflow,
  output logic [15:0] o_byte_cnt,
  output logic [15:0] o_checksum
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_DRAIN, S_DONE} state_t;

  state_t      r_state;
  state_t      w_state_nxt;

  logic [15:0] r_len;
  logic [15:0] r_cnt;
  logic [31:0] r_asm;
  logic        r_ovf;

  logic [31:0] r_fifo_word [DEPTH];
  logic [3:0]  r_fifo_en   [DEPTH];
  logic        r_fifo_last [DEPTH];
  logic [AW:0] r_wptr;
  logic [AW:0] r_rptr;

  logic        w_empty;
  logic        w_full;
  logic [AW:0] w_count;
  logic        w_pop;
  logic        w_take;
  logic [1:0]  w_lane;
  logic        w_is_last;
  logic        w_push;
  logic        w_write;
  logic        w_drop;
  logic        w_drain_done;
  logic [31:0] w_asm_nxt;
  logic [3:0]  w_en;

  // FIFO status; the extra pointer bit separates full from empty
  assign w_empty = (r_wptr == r_rptr);
  assign w_full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign w_count = r_wptr - r_rptr;
  assign w_pop   = !w_empty && i_word_ready;

  // A byte is only taken in ACTIVE; a byte coincident with i_start belongs to neither transfer
  assign w_take    = (r_state == S_ACTIVE) && i_byte_valid && !i_start;
  assign w_lane    = r_cnt[1:0];
  assign w_is_last = ((r_cnt + 16'd1) == r_len);
  assign w_push    = w_take && ((w_lane == 2'd3) || w_is_last);
  // A simultaneous pop frees a slot, so full alone is not a drop
  assign w_drop    = w_push && w_full && !w_pop;
  assign w_write   = w_push && !w_drop;
  // Only pops happen in DRAIN, so the FIFO empties after popping its single remaining entry
  assign w_drain_done = w_empty || ((w_count == {{AW{1'b0}}, 1'b1}) && w_pop);

  // Merge the incoming byte into its lane; higher lanes are still zero from the last clear
  always_comb begin
    w_asm_nxt = r_asm;
    w_asm_nxt[8*w_lane +: 8] = i_byte;
  end

  // Byte enables cover every lane written up to and including the current one
  always_comb begin
    w_en = 4'b0000;
    case (w_lane)
      2'd0:    w_en = 4'b0001;
      2'd1:    w_en = 4'b0011;
      2'd2:    w_en = 4'b0111;
      default: w_en = 4'b1111;
    endcase
  end

  // State register
  always_ff @(posedge CLK) begin
    if (RESET) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next-state and status outputs; i_start overrides every state
  always_comb begin
    w_state_nxt = r_state;
    o_busy      = 1'b0;
    o_done      = 1'b0;
    case (r_state)
      S_ACTIVE: begin
        o_busy = 1'b1;
        if (w_push && w_is_last) w_state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        o_busy = 1'b1;
        if (w_drain_done) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        o_done      = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = r_state;
    endcase
    if (i_start) w_state_nxt = (i_byte_len == 16'd0) ? S_DONE : S_ACTIVE;
  end

  // Counters, assembly register, FIFO pointers and sticky overflow
  always_ff @(posedge CLK) begin
    if (RESET || i_start) begin
      r_len  <= RESET ? 16'd0 : i_byte_len;
      r_cnt  <= 16'd0;
      r_asm  <= 32'd0;
      r_ovf  <= 1'b0;
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_take) begin
        r_cnt <= r_cnt + 16'd1;
        r_asm <= w_push ? 32'd0 : w_asm_nxt;
      end
      if (w_pop)   r_rptr <= r_rptr + 1'b1;
      if (w_write) r_wptr <= r_wptr + 1'b1;
      if (w_drop)  r_ovf  <= 1'b1;
    end
  end

  // FIFO storage; contents need no reset because the pointers gate visibility
  always_ff @(posedge CLK) begin
    if (!RESET && !i_start && w_write) begin
      r_fifo_word[r_wptr[AW-1:0]] <= w_asm_nxt;
      r_fifo_en[r_wptr[AW-1:0]]   <= w_en;
      r_fifo_last[r_wptr[AW-1:0]] <= w_is_last;
    end
  end

  // Head entry is shown only while valid, so outputs read zero when the FIFO is empty
  assign o_word_valid = !w_empty;
  assign o_word       = w_empty ? 32'd0 : r_fifo_word[r_rptr[AW-1:0]];
  assign o_byte_en    = w_empty ? 4'd0  : r_fifo_en[r_rptr[AW-1:0]];
  assign o_last       = w_empty ? 1'b0  : r_fifo_last[r_rptr[AW-1:0]];
  assign o_overflow   = r_ovf;
  assign o_byte_cnt   = r_cnt;

`ifdef PACKER_CHECKSUM_EN
  logic [15:0] r_csum;

  // Running sum of every byte taken in ACTIVE, dropped words included
  always_ff @(posedge CLK) begin
    if (RESET || i_start) r_csum <= 16'd0;
    else if (w_take)      r_csum <= r_csum + {8'h00, i_byte};
  end

  assign o_checksum = r_csum;
`else
  assign o_checksum = 16'h0000;
`endif

endmodule

// File: tb/tb_byte_stream_packer.sv
// tb_byte_stream_packer: directed stimulus against byte_stream_packer with DEPTH=4.
// Inputs are driven 1 time unit after the rising edge and outputs are checked at the same point.
// Checksum expectations collapse to zero when PACKER_CHECKSUM_EN is not defined.
module tb_byte_stream_packer;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic        i_start = 1'b0;
  logic [15:0] i_byte_len = 16'd0;
  logic [7:0]  i_byte = 8'd0;
  logic        i_byte_valid = 1'b0;
  logic        i_word_ready = 1'b0;
  logic [31:0] o_word;
  logic [3:0]  o_byte_en;
  logic        o_last;
  logic        o_word_valid;
  logic        o_busy;
  logic        o_done;
  logic        o_overflow;
  logic [15:0] o_byte_cnt;
  logic [15:0] o_checksum;

  int total = 0;
  int bad   = 0;

  byte_stream_packer #(.DEPTH(4)) dut (
    .CLK(CLK), .RESET(RESET), .i_start(i_start), .i_byte_len(i_byte_len),
    .i_byte(i_byte), .i_byte_valid(i_byte_valid), .o_word(o_word),
    .o_byte_en(o_byte_en), .o_last(o_last), .o_word_valid(o_word_valid),
    .i_word_ready(i_word_ready), .o_busy(o_busy), .o_done(o_done),
    .o_overflow(o_overflow), .o_byte_cnt(o_byte_cnt), .o_checksum(o_checksum)
  );

  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [31:0] csum(input logic [31:0] v);
`ifdef PACKER_CHECKSUM_EN
    return v;
`else
    return 32'd0 & v;
`endif
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic start(input logic [15:0] len);
    i_start    = 1'b1;
    i_byte_len = len;
    tick();
    i_start    = 1'b0;
  endtask

  task automatic send(input logic [7:0] b);
    i_byte       = b;
    i_byte_valid = 1'b1;
    tick();
    i_byte_valid = 1'b0;
  endtask

  task automatic chk_word(input string tag, input logic [31:0] w, input logic [3:0] en, input logic last);
    chk({tag, ".vld"},  {31'd0, o_word_valid}, 32'd1);
    chk({tag, ".word"}, o_word, w);
    chk({tag, ".en"},   {28'd0, o_byte_en}, {28'd0, en});
    chk({tag, ".last"}, {31'd0, o_last}, {31'd0, last});
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, ".word"}, o_word, 32'd0);
    chk({tag, ".en"},   {28'd0, o_byte_en}, 32'd0);
    chk({tag, ".last"}, {31'd0, o_last}, 32'd0);
    chk({tag, ".vld"},  {31'd0, o_word_valid}, 32'd0);
    chk({tag, ".busy"}, {31'd0, o_busy}, 32'd0);
    chk({tag, ".done"}, {31'd0, o_done}, 32'd0);
    chk({tag, ".ovf"},  {31'd0, o_overflow}, 32'd0);
    chk({tag, ".cnt"},  {16'd0, o_byte_cnt}, 32'd0);
    chk({tag, ".csum"}, {16'd0, o_checksum}, 32'd0);
  endtask

  initial begin
    // Reset state
    #1;
    tick();
    tick();
    chk_idle("rst");
    RESET = 1'b0;
    tick();

    // Bytes outside a transfer are ignored
    send(8'h5A);
    chk("idle_ign.cnt", {16'd0, o_byte_cnt}, 32'd0);
    chk("idle_ign.vld", {31'd0, o_word_valid}, 32'd0);

    // Basic transfer, len=8, ready=1
    i_word_ready = 1'b1;
    start(16'd8);
    chk("b.busy", {31'd0, o_busy}, 32'd1);
    for (int i = 1; i <= 8; i++) begin
      send(8'(i));
      if (i == 4) begin
        chk_word("b.w0", 32'h04030201, 4'hF, 1'b0);
        chk("b.cnt4", {16'd0, o_byte_cnt}, 32'd4);
      end
    end
    chk_word("b.w1", 32'h08070605, 4'hF, 1'b1);
    chk("b.cnt8", {16'd0, o_byte_cnt}, 32'd8);
    chk("b.csum", {16'd0, o_checksum}, csum(32'h0024));
    chk("b.done_early", {31'd0, o_done}, 32'd0);
    tick();
    chk("b.done", {31'd0, o_done}, 32'd1);
    chk("b.vld_after", {31'd0, o_word_valid}, 32'd0);
    chk("b.busy_done", {31'd0, o_busy}, 32'd0);
    tick();
    chk("b.done_pulse", {31'd0, o_done}, 32'd0);

    // Partial last word, len=6
    start(16'd6);
    send(8'hAA); send(8'hBB); send(8'hCC); send(8'hDD);
    chk_word("p.w0", 32'hDDCCBBAA, 4'hF, 1'b0);
    send(8'hEE); send(8'hFF);
    chk_word("p.w1", 32'h0000FFEE, 4'b0011, 1'b1);
    chk("p.cnt", {16'd0, o_byte_cnt}, 32'd6);
    chk("p.csum", {16'd0, o_checksum}, csum(32'h04FB));
    tick();
    chk("p.done", {31'd0, o_done}, 32'd1);
    tick();

    // Backpressure and overflow, len=24, ready=0
    i_word_ready = 1'b0;
    start(16'd24);
    for (int i = 1; i <= 24; i++) begin
      send(8'(i));
      if (i == 16) begin
        chk("o.ovf_full", {31'd0, o_overflow}, 32'd0);
        chk_word("o.head16", 32'h04030201, 4'hF, 1'b0);
      end
    end
    chk("o.ovf", {31'd0, o_overflow}, 32'd1);
    chk("o.busy", {31'd0, o_busy}, 32'd1);
    chk("o.cnt", {16'd0, o_byte_cnt}, 32'd24);
    chk("o.csum", {16'd0, o_checksum}, csum(32'h012C));
    tick();
    chk("o.stall_done", {31'd0, o_done}, 32'd0);
    chk_word("o.stall", 32'h04030201, 4'hF, 1'b0);
    i_word_ready = 1'b1;
    chk_word("o.d0", 32'h04030201, 4'hF, 1'b0);
    tick();
    chk_word("o.d1", 32'h08070605, 4'hF, 1'b0);
    tick();
    chk_word("o.d2", 32'h0C0B0A09, 4'hF, 1'b0);
    tick();
    chk_word("o.d3", 32'h100F0E0D, 4'hF, 1'b0);
    chk("o.pre_done", {31'd0, o_done}, 32'd0);
    tick();
    chk("o.done", {31'd0, o_done}, 32'd1);
    chk("o.vld_after", {31'd0, o_word_valid}, 32'd0);
    chk("o.ovf_sticky", {31'd0, o_overflow}, 32'd1);
    tick();

    // Empty transfer; start also clears overflow
    start(16'd0);
    chk("e.done", {31'd0, o_done}, 32'd1);
    chk("e.busy", {31'd0, o_busy}, 32'd0);
    chk("e.vld", {31'd0, o_word_valid}, 32'd0);
    chk("e.ovf_clr", {31'd0, o_overflow}, 32'd0);
    tick();
    chk("e.done_pulse", {31'd0, o_done}, 32'd0);
    chk("e.busy2", {31'd0, o_busy}, 32'd0);

    // Restart mid-transfer with a coincident byte
    i_word_ready = 1'b0;
    start(16'd8);
    send(8'h10); send(8'h11); send(8'h12); send(8'h13); send(8'h14);
    chk("r.cnt5", {16'd0, o_byte_cnt}, 32'd5);
    chk("r.vld_pre", {31'd0, o_word_valid}, 32'd1);
    i_start      = 1'b1;
    i_byte_len   = 16'd4;
    i_byte       = 8'h99;
    i_byte_valid = 1'b1;
    tick();
    i_start      = 1'b0;
    i_byte_valid = 1'b0;
    chk("r.cnt0", {16'd0, o_byte_cnt}, 32'd0);
    chk("r.flush", {31'd0, o_word_valid}, 32'd0);
    chk("r.csum0", {16'd0, o_checksum}, 32'd0);
    chk("r.busy", {31'd0, o_busy}, 32'd1);
    i_word_ready = 1'b1;
    send(8'h21); send(8'h22); send(8'h23); send(8'h24);
    chk_word("r.w", 32'h24232221, 4'hF, 1'b1);
    chk("r.csum", {16'd0, o_checksum}, csum(32'h008A));
    tick();
    chk("r.done", {31'd0, o_done}, 32'd1);
    chk("r.one_word", {31'd0, o_word_valid}, 32'd0);
    tick();

    // Reset mid-transfer
    i_word_ready = 1'b0;
    start(16'd8);
    send(8'h31); send(8'h32); send(8'h33); send(8'h34); send(8'h35);
    chk("x.vld_pre", {31'd0, o_word_valid}, 32'd1);
    RESET = 1'b1;
    tick();
    RESET = 1'b0;
    chk_idle("x.rst");
    tick();
    chk("x.no_done", {31'd0, o_done}, 32'd0);
    chk("x.idle", {31'd0, o_busy}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
